// File: rtl/hex_pkg.sv
// Shared types and seven-segment helpers for the hex stopwatch controller.
// Segment codes are gfedcba, common anode (0 = segment lit).
package hex_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_e;

  // One-cycle debounced press events
  typedef struct packed {
    logic clr;
    logic start;
    logic lap;
  } btn_evt_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hex_stopwatch_ctrl_pb_debounce.sv
// Active-low push-button debouncer: 2-flop synchronizer, stable-sample counter,
// registered one-cycle pulse on each accepted press.
module pb_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          samp;

  assign samp = ~sync[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync        <= 2'b11;
      cnt         <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_n};
      press_pulse <= 1'b0;
      if (samp == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // Nth consecutive differing sample: accept the new level
        cnt         <= '0;
        pressed     <= samp;
        press_pulse <= samp;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hex_stopwatch_ctrl.sv
// 4-digit BCD stopwatch: debounced buttons drive a run/pause/lap/clear FSM,
// a tick prescaler and BCD counter; displays show live count or frozen lap.
module hex_stopwatch_ctrl
  import hex_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 20_000_000,
  parameter int          DEB_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] PB,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [7:0] LEDG
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sw_state_e       state, state_nx;
  btn_evt_t        evt;
  logic [2:0]      deb_pulse, deb_lvl_unused;
  logic            unused_pb0;
  logic [PW-1:0]   presc;
  logic [3:0][3:0] cnt, cnt_inc, lap_q, disp;
  logic            wrap, counting, tick, do_clear, do_cap, ovf;

  assign unused_pb0 = PB[0];

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [2:0] (
    .CLK         (CLK),
    .RST         (RST),
    .btn_n       (PB[3:1]),
    .pressed     (deb_lvl_unused),
    .press_pulse (deb_pulse)
  );

  assign evt = '{clr: deb_pulse[1], start: deb_pulse[0], lap: deb_pulse[2]};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Highest-priority pulse valid in the current state wins; the rest drop
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!evt.clr && evt.start) state_nx = RUN;
      RUN:     if (evt.start) state_nx = PAUSE;
               else if (evt.lap) state_nx = LAP;
      LAP:     if (evt.start) state_nx = PAUSE;
               else if (evt.lap) state_nx = RUN;
      PAUSE:   if (evt.clr) state_nx = IDLE;
               else if (evt.start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_clear = 1'b0;
    do_cap   = 1'b0;
    counting = 1'b0;
    LEDG     = 8'h00;
    case (state)
      IDLE:    begin do_clear = evt.clr; LEDG[3] = 1'b1; end
      RUN:     begin do_cap = !evt.start && evt.lap; counting = 1'b1; LEDG[0] = 1'b1; end
      LAP:     begin counting = 1'b1; LEDG[0] = 1'b1; LEDG[2] = 1'b1; end
      PAUSE:   begin do_clear = evt.clr; LEDG[1] = 1'b1; end
      default: ;
    endcase
    LEDG[7] = ovf;
  end

  assign tick = counting && (presc == PW'(TICK_DIV - 1));

  always_comb begin
    cnt_inc = cnt;
    wrap    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wrap) begin
        if (cnt[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt[i] + 4'd1;
          wrap       = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      cnt   <= '0;
      lap_q <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_clear) begin
        presc <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (counting) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          cnt <= cnt_inc;
          if (wrap) ovf <= 1'b1;
        end
      end
      if (do_cap) lap_q <= cnt;
    end
  end

  assign disp = (state == LAP) ? lap_q : cnt;
  assign HEX0 = bcd_to_seg(disp[0]);
  assign HEX1 = bcd_to_seg(disp[1]);
  assign HEX2 = bcd_to_seg(disp[2]);
  assign HEX3 = bcd_to_seg(disp[3]);

endmodule
